safety_island_boot_ctrl: RTL and testbench

//  Sequences safety-island core start-up: holds core in reset, latches bootmode, waits for boot condition, releases fetch.

---
 rtl/safety_island_pkg.sv | 21 ++
 rtl/safety_island_boot_ctrl.sv | 140 ++++++++++++++
 tb/tb_safety_island_boot_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety-island boot controller.
package safety_island_pkg;

    typedef enum logic [1:0] {
        Jtag      = 2'b00,
        Preloaded = 2'b01
    } bootmode_e;

    typedef enum logic [2:0] {
        Hold        = 3'd0,
        WaitJtag    = 3'd1,
        WaitPreload = 3'd2,
        Release     = 3'd3,
        Running     = 3'd4,
        Error       = 3'd5
    } boot_state_e;

    localparam logic [31:0] BootROMAddrOffset      = 32'h0000_1000;
    localparam logic [31:0] PreloadBootAddrDefault = BootROMAddrOffset + 32'h0000_0080;

endpackage

// File: rtl/safety_island_boot_ctrl.sv
// Safety-island core start-up sequencer: reset hold, bootmode latch, boot
// condition wait and fetch release with a sticky error path.
module safety_island_boot_ctrl
    import safety_island_pkg::*;
#(
    parameter int unsigned ResetHoldCycles = 16,
    parameter logic [31:0] PreloadTimeout  = 32'h0010_0000,
    parameter logic [31:0] PreloadBootAddr = PreloadBootAddrDefault,
    parameter int unsigned CntWidth        = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  bootmode_i,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_req_i,
    input  logic        preload_done_i,
    input  logic        soft_rst_req_i,
    output logic        core_rst_no,
    output logic        fetch_enable_o,
    output logic [31:0] boot_addr_o,
    output logic [2:0]  state_o,
    output logic        boot_err_o
);

    localparam logic [CntWidth-1:0] HoldLast    = CntWidth'(ResetHoldCycles - 32'd1);
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(PreloadTimeout - 32'd1);
    localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntMax      = {CntWidth{1'b1}};
    localparam bit                  TimeoutEn   = (PreloadTimeout != 32'd0);

    boot_state_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]         addr_q, addr_d;
    logic                err_q, err_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                fetch_q, fetch_d;

    // Saturating increment: a stuck counter never wraps back into a false match.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;

        if (soft_rst_req_i && (state_q != Hold)) begin
            state_d = Hold;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                Hold: begin
                    if (cnt_q == HoldLast) begin
                        cnt_d = '0;
                        case (bootmode_e'(bootmode_i))
                            Jtag:      state_d = WaitJtag;
                            Preloaded: state_d = WaitPreload;
                            default: begin
                                state_d = Error;
                                err_d   = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WaitJtag: begin
                    if (fetch_en_req_i) begin
                        addr_d  = boot_addr_i;
                        state_d = Release;
                    end
                end
                WaitPreload: begin
                    cnt_d = cnt_inc;
                    // Completion on the timeout cycle still boots.
                    if (preload_done_i) begin
                        addr_d  = PreloadBootAddr;
                        state_d = Release;
                        cnt_d   = '0;
                    end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                        state_d = Error;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                Release:  state_d = Running;
                Running:  state_d = Running;
                Error:    state_d = Error;
                default:  state_d = Hold;
            endcase
        end
    end

    // Outputs decoded from the next state so every output is a flop.
    always_comb begin
        core_rst_n_d = 1'b0;
        fetch_d      = 1'b0;
        case (state_d)
            WaitJtag, WaitPreload, Release: core_rst_n_d = 1'b1;
            Running: begin
                core_rst_n_d = 1'b1;
                fetch_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Hold;
            cnt_q        <= '0;
            addr_q       <= '0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            fetch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
            fetch_q      <= fetch_d;
        end
    end

    assign core_rst_no    = core_rst_n_q;
    assign fetch_enable_o = fetch_q;
    assign boot_addr_o    = addr_q;
    assign state_o        = state_q;
    assign boot_err_o     = err_q;

`ifndef SYNTHESIS
    fetch_needs_core_out_of_reset: assert property (
        @(posedge clk_i) disable iff (!rst_ni) fetch_enable_o |-> core_rst_no);
    boot_addr_stable_while_fetching: assert property (
        @(posedge clk_i) disable iff (!rst_ni) fetch_enable_o |-> $stable(boot_addr_o));
`endif

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Directed bench for the safety-island boot controller.
module tb_safety_island_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  bootmode = 2'b00;
    logic [31:0] boot_addr = 32'h0;
    logic        fetch_en_req = 1'b0;
    logic        preload_done = 1'b0;
    logic        soft_rst_req = 1'b0;
    logic        core_rst_n;
    logic        fetch_enable;
    logic [31:0] boot_addr_out;
    logic [2:0]  state;
    logic        boot_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] S_HOLD = 3'd0, S_WJTAG = 3'd1, S_WPRE = 3'd2,
                           S_REL = 3'd3, S_RUN = 3'd4, S_ERR = 3'd5;

    safety_island_boot_ctrl #(
        .ResetHoldCycles(16),
        .PreloadTimeout (32'd64),
        .PreloadBootAddr(32'h0000_1080),
        .CntWidth       (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .bootmode_i    (bootmode),
        .boot_addr_i   (boot_addr),
        .fetch_en_req_i(fetch_en_req),
        .preload_done_i(preload_done),
        .soft_rst_req_i(soft_rst_req),
        .core_rst_no   (core_rst_n),
        .fetch_enable_o(fetch_enable),
        .boot_addr_o   (boot_addr_out),
        .state_o       (state),
        .boot_err_o    (boot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic rst_n_e, input logic fe_e,
                        input logic [31:0] addr_e, input logic [2:0] st_e, input logic err_e);
        chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(rst_n_e));
        chk({tag, ".fetch_en"},   32'(fetch_enable), 32'(fe_e));
        chk({tag, ".boot_addr"},  boot_addr_out, addr_e);
        chk({tag, ".state"},      32'(state), 32'(st_e));
        chk({tag, ".boot_err"},   32'(boot_err), 32'(err_e));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset values
        #12;
        outs("por", 1'b0, 1'b0, 32'h0, S_HOLD, 1'b0);
        rst_ni = 1'b1;

        // T1 Jtag boot
        boot_addr = 32'h1C00_0080;
        step(15);
        outs("t1.hold15", 1'b0, 1'b0, 32'h0, S_HOLD, 1'b0);
        step(1);
        outs("t1.waitjtag", 1'b1, 1'b0, 32'h0, S_WJTAG, 1'b0);
        step(8);
        chk("t1.still_wait", 32'(state), 32'(S_WJTAG));
        fetch_en_req = 1'b1;
        step(1);
        outs("t1.release", 1'b1, 1'b0, 32'h1C00_0080, S_REL, 1'b0);
        step(1);
        outs("t1.running", 1'b1, 1'b1, 32'h1C00_0080, S_RUN, 1'b0);

        // T5 inputs ignored while running, then soft restart
        boot_addr = 32'hDEAD_BEEF;
        fetch_en_req = 1'b0;
        bootmode = 2'b11;
        step(3);
        outs("t5.ignore", 1'b1, 1'b1, 32'h1C00_0080, S_RUN, 1'b0);
        soft_pulse();
        outs("t5.softrst", 1'b0, 1'b0, 32'h1C00_0080, S_HOLD, 1'b0);

        // T4 illegal bootmode; soft pulse in Hold does not restart the count
        step(5);
        soft_pulse();
        step(9);
        chk("t4.hold15", 32'(state), 32'(S_HOLD));
        step(1);
        outs("t4.error", 1'b0, 1'b0, 32'h1C00_0080, S_ERR, 1'b1);
        step(3);
        chk("t4.sticky", 32'(boot_err), 32'd1);
        bootmode = 2'b00;
        boot_addr = 32'h1C00_0100;
        fetch_en_req = 1'b1;
        soft_pulse();
        chk("t4.err_clear", 32'(boot_err), 32'd0);
        chk("t4.hold", 32'(state), 32'(S_HOLD));
        step(16);
        chk("t4.waitjtag", 32'(state), 32'(S_WJTAG));
        step(1);
        outs("t4.release", 1'b1, 1'b0, 32'h1C00_0100, S_REL, 1'b0);
        step(1);
        outs("t4.running", 1'b1, 1'b1, 32'h1C00_0100, S_RUN, 1'b0);

        // T6 async reset while running, full hold on restart
        fetch_en_req = 1'b0;
        rst_ni = 1'b0;
        #1;
        outs("t6.rst_run", 1'b0, 1'b0, 32'h0, S_HOLD, 1'b0);
        bootmode = 2'b01;
        rst_ni = 1'b1;
        step(15);
        chk("t6.hold15", 32'(state), 32'(S_HOLD));
        step(1);
        outs("t2.waitpre", 1'b1, 1'b0, 32'h0, S_WPRE, 1'b0);

        // T2 preloaded boot
        step(20);
        chk("t2.still_wait", 32'(state), 32'(S_WPRE));
        preload_done = 1'b1;
        step(1);
        outs("t2.release", 1'b1, 1'b0, 32'h0000_1080, S_REL, 1'b0);
        step(1);
        outs("t2.running", 1'b1, 1'b1, 32'h0000_1080, S_RUN, 1'b0);

        // T6 async reset while waiting for preload
        preload_done = 1'b0;
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        step(16);
        chk("t6.wp_enter", 32'(state), 32'(S_WPRE));
        step(5);
        rst_ni = 1'b0;
        #1;
        outs("t6.rst_wp", 1'b0, 1'b0, 32'h0, S_HOLD, 1'b0);
        rst_ni = 1'b1;

        // T3 preload timeout
        step(16);
        chk("t3.waitpre", 32'(state), 32'(S_WPRE));
        step(63);
        chk("t3.before_to", 32'(state), 32'(S_WPRE));
        step(1);
        outs("t3.timeout", 1'b0, 1'b0, 32'h0, S_ERR, 1'b1);

        // T3b done on the timeout cycle wins
        soft_pulse();
        chk("t3b.hold", 32'(state), 32'(S_HOLD));
        step(16);
        step(63);
        chk("t3b.before_to", 32'(state), 32'(S_WPRE));
        preload_done = 1'b1;
        step(1);
        outs("t3b.release", 1'b1, 1'b0, 32'h0000_1080, S_REL, 1'b0);
        step(1);
        outs("t3b.running", 1'b1, 1'b1, 32'h0000_1080, S_RUN, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
